// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state types and divider constants for the multiply/divide scheduler
package mdu_pkg;
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_DIV   = 3'd1,
        OP_DIVU  = 3'd2,
        OP_MADD  = 3'd3,
        OP_MADDU = 3'd4,
        OP_MSUB  = 3'd5,
        OP_MSUBU = 3'd6
    } mdu_op_t;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIV  = 3'd1,
        ST_FIX  = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_t;
    localparam logic [31:0] DIV_ZERO_Q    = 32'hFFFF_FFFF;
    localparam int          MDU_DIV_ITERS = 32;
    localparam int          MDU_ITER_W    = $clog2(MDU_DIV_ITERS + 1);
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one radix-2 restoring shift-subtract step; quo_i carries the unconsumed dividend bits
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] sh, diff;
    assign sh    = {rem_i, quo_i[XLEN-1]};
    assign diff  = sh - {1'b0, dvs_i};
    assign rem_o = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle DIV/DIVU sequencer with HI/LO writeback; MDU_ACC_EN adds MADD/MSUB accumulate ops
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = MDU_DIV_ITERS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            hold_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic [63:0]     mul_i,
    input  logic [63:0]     hilo_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            hilo_we_o,
    output logic [63:0]     hilo_o,
    output logic            busy_o
);
    mdu_state_t            state_q, state_d;
    logic [XLEN-1:0]       rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [MDU_ITER_W-1:0] cnt_q, cnt_d;
    logic                  qneg_q, qneg_d, rneg_q, rneg_d, wr_q;
    logic [XLEN-1:0]       step_rem, step_quo, abs_a, abs_b;
    logic                  is_div, is_sdiv, is_acc, req, accept;
`ifdef MDU_ACC_EN
    logic [63:0]           mul_q, mul_d;
    logic                  sub_q, sub_d;
    assign is_acc = op_i == OP_MADD || op_i == OP_MADDU || op_i == OP_MSUB || op_i == OP_MSUBU;
`else
    logic                  unused_acc;
    assign unused_acc = ^{mul_i, hilo_i};
    assign is_acc     = 1'b0;
`endif
    assign is_sdiv   = op_i == OP_DIV;
    assign is_div    = is_sdiv || op_i == OP_DIVU;
    assign abs_a     = (is_sdiv && src_a_i[XLEN-1]) ? -src_a_i : src_a_i;
    assign abs_b     = (is_sdiv && src_b_i[XLEN-1]) ? -src_b_i : src_b_i;
    assign req       = state_q == ST_IDLE && start_i && (is_div || is_acc);
    assign accept    = req && !flush_i;
    assign stall_o   = !flush_i && (req || state_q == ST_DIV || state_q == ST_FIX || state_q == ST_ACC);
    assign done_o    = !flush_i && state_q == ST_DONE;
    assign hilo_we_o = done_o && !wr_q;
    assign hilo_o    = {rem_q, quo_q};
    assign busy_o    = state_q != ST_IDLE;

    mdu_div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // next-state and datapath update for the op sequence; a flush always wins and returns to idle
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`ifdef MDU_ACC_EN
        mul_d   = mul_q;
        sub_d   = sub_q;
`endif
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && is_div) begin
                        qneg_d  = is_sdiv && (src_a_i[XLEN-1] ^ src_b_i[XLEN-1]);
                        rneg_d  = is_sdiv && src_a_i[XLEN-1];
                        dvs_d   = abs_b;
                        cnt_d   = '0;
                        rem_d   = src_b_i == '0 ? src_a_i : '0;
                        quo_d   = src_b_i == '0 ? DIV_ZERO_Q : abs_a;
                        state_d = src_b_i == '0 ? ST_DONE : ST_DIV;
                    end
`ifdef MDU_ACC_EN
                    if (accept && is_acc) begin
                        {rem_d, quo_d} = hilo_i;
                        mul_d   = mul_i;
                        sub_d   = op_i == OP_MSUB || op_i == OP_MSUBU;
                        state_d = ST_ACC;
                    end
`endif
                end
                ST_DIV: begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    cnt_d   = cnt_q + MDU_ITER_W'(1);
                    state_d = cnt_q == MDU_ITER_W'(DIV_ITERS - 1) ? ST_FIX : ST_DIV;
                end
                ST_FIX: begin
                    quo_d   = qneg_q ? -quo_q : quo_q;
                    rem_d   = rneg_q ? -rem_q : rem_q;
                    state_d = ST_DONE;
                end
`ifdef MDU_ACC_EN
                ST_ACC: begin
                    {rem_d, quo_d} = sub_q ? {rem_q, quo_q} - mul_q : {rem_q, quo_q} + mul_q;
                    state_d = ST_DONE;
                end
`endif
                ST_DONE: state_d = hold_i ? ST_DONE : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state and datapath registers; wr_q marks that the single HI/LO write has already happened
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            wr_q    <= 1'b0;
`ifdef MDU_ACC_EN
            mul_q   <= '0;
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            wr_q    <= state_q == ST_DONE;
`ifdef MDU_ACC_EN
            mul_q   <= mul_d;
            sub_q   <= sub_d;
`endif
        end
    end
endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed and random checks of mdu_sched against an arithmetic reference model
module tb_mdu_sched;
    import mdu_pkg::*;
    logic        clk = 1'b0, rst = 1'b0, flush_i = 1'b0, hold_i = 1'b0, start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] src_a_i = '0, src_b_i = '0;
    logic [63:0] mul_i = '0, hilo_i = '0;
    logic        stall_o, done_o, hilo_we_o, busy_o;
    logic [63:0] hilo_o;
    int          n_chk = 0, n_fail = 0;

    mdu_sched dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .hold_i    (hold_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .src_a_i   (src_a_i),
        .src_b_i   (src_b_i),
        .mul_i     (mul_i),
        .hilo_i    (hilo_i),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .hilo_we_o (hilo_we_o),
        .hilo_o    (hilo_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit acc_op(input logic [2:0] op);
        return op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU;
    endfunction

    // cycles from start to done_o; 0 means the op is not accepted
    function automatic int latency(input logic [2:0] op, input logic [31:0] b);
        if (op == OP_DIV || op == OP_DIVU) return b == 0 ? 1 : 34;
`ifdef MDU_ACC_EN
        if (acc_op(op)) return 2;
`endif
        return 0;
    endfunction

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] mul, input logic [63:0] hl);
        longint sa, sb, q, r;
        if ((op == OP_DIV || op == OP_DIVU) && b == 0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIVU) return {a % b, a / b};
        if (op == OP_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        if (op == OP_MADD || op == OP_MADDU) return hl + mul;
        return hl - mul;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] mul, input logic [63:0] hl, input int hold_n);
        logic [63:0] exp;
        int          lat, cyc;
        bit          stall_bad;
        exp = model(op, a, b, mul, hl);
        lat = latency(op, b);
        @(negedge clk);
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b; mul_i = mul; hilo_i = hl;
        #1;
        chk({tag, "_stall_start"}, {63'd0, stall_o}, {63'd0, lat != 0});
        if (lat == 0) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            chk({tag, "_ignored_busy"}, {63'd0, busy_o}, 64'd0);
            chk({tag, "_ignored_we"}, {63'd0, hilo_we_o}, 64'd0);
            return;
        end
        cyc = 0;
        stall_bad = 0;
        do begin
            @(negedge clk);
            start_i = 1'b0;
            cyc++;
            #1;
            if (!done_o && !stall_o) stall_bad = 1;
        end while (!done_o && cyc < 100);
        hold_i = hold_n > 0;
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_hilo"}, hilo_o, exp);
        chk({tag, "_we"}, {63'd0, hilo_we_o}, 64'd1);
        chk({tag, "_stall_busy_window"}, {62'd0, stall_bad, stall_o}, 64'd0);
        for (int k = 1; k <= hold_n; k++) begin
            @(negedge clk);
            #1;
            chk({tag, "_hold_done"}, {63'd0, done_o}, 64'd1);
            chk({tag, "_hold_we"}, {63'd0, hilo_we_o}, 64'd0);
            chk({tag, "_hold_hilo"}, hilo_o, exp);
            hold_i = k < hold_n;
        end
        @(negedge clk);
        #1;
        chk({tag, "_after_done"}, {62'd0, done_o, busy_o}, 64'd0);
    endtask

    initial begin
        int          we_seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", {60'd0, stall_o, done_o, hilo_we_o, busy_o}, 64'd0);
        chk("reset_hilo", hilo_o, 64'd0);
        rst = 1'b1;
        // directed divides
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, '0, '0, 0);
        run_op("div_m7_2", OP_DIV, -32'sd7, 32'd2, '0, '0, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, 0);
        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, '0, '0, 0);
        run_op("divu_neg_0", OP_DIVU, 32'hF000_0001, 32'd0, '0, '0, 0);
        run_op("div_7_m2", OP_DIV, 32'd7, -32'sd2, '0, '0, 0);
        run_op("divu_hold", OP_DIVU, 32'hDEAD_BEEF, 32'd1234, '0, '0, 3);
        run_op("div0_hold", OP_DIV, -32'sd9, 32'd0, '0, '0, 2);
        // ops that must be ignored
        run_op("op_none", OP_NONE, 32'd10, 32'd2, '0, '0, 0);
        run_op("op_bad", 3'd7, 32'd10, 32'd2, '0, '0, 0);
        // accumulate ops (accepted only when compiled in)
        run_op("maddu_carry", OP_MADDU, '0, '0, 64'd1, 64'h1_FFFF_FFFF, 0);
        run_op("msub_wrap", OP_MSUB, '0, '0, 64'd5, 64'd3, 1);
        run_op("madd_neg", OP_MADD, '0, '0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd100, 0);
        run_op("msubu", OP_MSUBU, '0, '0, 64'h1234, 64'h1_0000_0000, 0);
        // flush mid-divide
        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIV; src_a_i = 32'd1000; src_b_i = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        flush_i = 1'b1;
        #1;
        chk("flush_cycle", {61'd0, stall_o, hilo_we_o, done_o}, 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush_idle", {62'd0, busy_o, stall_o}, 64'd0);
        we_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (hilo_we_o || busy_o) we_seen++;
        end
        chk("flush_no_write", 64'(we_seen), 64'd0);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, '0, '0, 0);
        // flush together with start in idle: op not accepted
        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIVU; flush_i = 1'b1;
        #1;
        chk("flush_start_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("flush_start_busy", {63'd0, busy_o}, 64'd0);
        // reset mid-divide clears everything
        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIVU; src_a_i = 32'd50; src_b_i = 32'd5;
        repeat (5) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("midreset_outs", {61'd0, busy_o, stall_o, done_o}, 64'd0);
        chk("midreset_hilo", hilo_o, 64'd0);
        rst = 1'b1;
        // random divides
        for (int i = 0; i < 24; i++) begin
            rop = $urandom_range(0, 1) ? OP_DIV : OP_DIVU;
            ra  = $urandom;
            rb  = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 5)) : $urandom;
            if ($urandom_range(0, 3) == 0) rb = -rb;
            run_op("rand_div", rop, ra, rb, '0, '0, $urandom_range(0, 2));
        end
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(3, 6));
            run_op("rand_acc", rop, '0, '0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
